// File: rtl/feat_bram_arbiter.sv
// Port-A arbiter for the new-feature BRAM: write priority, read starvation guard,
// read-after-write ordering on a shared address, fixed-latency read return.
module feat_bram_arbiter #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_ADDR_W = 16,
  parameter int BRAM_RD_LATENCY    = 2,
  parameter int STARVE_LIMIT       = 8,
  localparam int CNT_W             = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_req,
  input  logic [NEW_FEATURE_ADDR_W-1:0] wr_addr,
  input  logic [NEW_FEATURE_WIDTH-1:0]  wr_data,
  output logic                          wr_gnt,
  input  logic                          rd_req,
  input  logic [NEW_FEATURE_ADDR_W-1:0] rd_addr,
  output logic                          rd_gnt,
  output logic [NEW_FEATURE_WIDTH-1:0]  rd_data,
  output logic                          rd_data_vld,
  output logic [NEW_FEATURE_ADDR_W-1:0] bram_addra,
  output logic [NEW_FEATURE_WIDTH-1:0]  bram_dina,
  output logic                          bram_ena,
  output logic                          bram_wea,
  input  logic [NEW_FEATURE_WIDTH-1:0]  bram_douta,
  output logic [CNT_W-1:0]              starve_cnt_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {ARB_WR = 1'b0, ARB_RD = 1'b1} arb_state_e;

  arb_state_e                    state_q;
  logic [CNT_W-1:0]              starve_q, starve_d;
  logic                          raw_hit;
  logic [BRAM_RD_LATENCY:0]      vld_pipe_q;
  logic [NEW_FEATURE_WIDTH-1:0]  rd_data_q;
  logic [NEW_FEATURE_ADDR_W-1:0] addra_q;
  logic [NEW_FEATURE_WIDTH-1:0]  dina_q;
  logic                          ena_q, wea_q;

  // A same-address collision always lets the write through first, so the read
  // returns the freshly stored word.
  always_comb begin
    raw_hit = wr_req & rd_req & (wr_addr == rd_addr);
    wr_gnt  = 1'b0;
    rd_gnt  = 1'b0;
    if (!rst) begin
      if (state_q == ARB_WR) begin
        wr_gnt = wr_req;
        rd_gnt = rd_req & ~wr_req;
      end else begin
        rd_gnt = rd_req & ~raw_hit;
        wr_gnt = wr_req & ~rd_gnt;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!rd_req || rd_gnt)   starve_d = '0;
    else if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_WR;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (state_q == ARB_WR) begin
        if (starve_d == LIMIT) state_q <= ARB_RD;
      end else begin
        // a withdrawn read must not leave the arbiter stuck in read priority
        if (rd_gnt || !rd_req) state_q <= ARB_WR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
    end else begin
      ena_q <= wr_gnt | rd_gnt;
      wea_q <= wr_gnt;
      if (wr_gnt) begin
        addra_q <= wr_addr;
        dina_q  <= wr_data;
      end else if (rd_gnt) begin
        addra_q <= rd_addr;
      end
    end
  end

  // Bit k marks a read granted k+1 cycles ago; douta is sampled one stage
  // before the end so data and valid leave together.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      rd_data_q  <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[BRAM_RD_LATENCY-1:0], rd_gnt};
      if (vld_pipe_q[BRAM_RD_LATENCY-1]) rd_data_q <= bram_douta;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_data_vld  = vld_pipe_q[BRAM_RD_LATENCY];
  assign bram_addra   = addra_q;
  assign bram_dina    = dina_q;
  assign bram_ena     = ena_q;
  assign bram_wea     = wea_q;
  assign starve_cnt_o = starve_q;

endmodule
